rx_fifo_seq: RTL and testbench
==============================

# rx_fifo_seq

Receive-path sequencer for the Basic CAN RX FIFO. Takes frame bytes from the CAN bit-stream processor, writes them into the FIFO's current input slot, and commits the slot on a good end-of-frame or discards it on error. On the host side it turns the "release receive buffer" and "clear data overrun" commands into FIFO pulses and status bits, and generates the receive and overrun interrupts.

## Interface
Parameters:
- `P_MAX_BYTES`, default 10: maximum bytes per frame (2 ID/control + 8 data); must not exceed 16.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `nreset`  in  1  asynchronous reset, active low.
- `rx_start`  in  1  start-of-frame pulse.
- `rx_byte`  in  8  received byte.
- `rx_byte_vld`  in  1  one-cycle strobe qualifying `rx_byte`.
- `rx_eof`  in  1  frame-received-OK pulse.
- `rx_err`  in  1  frame-abort pulse.
- `rx_dsc`  in  2  descriptor bits; sampled with `rx_eof`.
- `rel_rx_buf`  in  1  host release-receive-buffer command pulse.
- `clr_ovr`  in  1  host clear-data-overrun command pulse.
- `rie`  in  1  receive interrupt enable.
- `oie`  in  1  overrun interrupt enable.
- `b_addr`  out  4  FIFO write address.
- `b_din`  out  8  FIFO write data.
- `b_wrn`  out  1  FIFO write strobe, active low.
- `b_next`  out  1  commit pulse: advance the input slot.
- `fifo_dsc`  out  2  descriptor to the FIFO; written with the last byte.
- `a_next`  out  1  release pulse: advance the output slot.
- `not_empty`  in  1  from FIFO.
- `full`  in  1  from FIFO.
- `overflow`  in  1  from FIFO; one-cycle pulse.
- `rbs`  out  1  receive buffer status.
- `dos`  out  1  data overrun status, sticky.
- `rx_irq`  out  1  receive interrupt.
- `ovr_irq`  out  1  overrun interrupt.
- `busy`  out  1  frame load in progress.

## Operation
States:
- **IDLE**: `rx_start` → LOAD, byte counter `cnt` := 0. Bytes, EOF and error strobes are ignored.
- **LOAD**, on `rx_byte_vld`:
  - If `cnt` < `P_MAX_BYTES`: write `rx_byte` at `b_addr` = `cnt`, then `cnt` +1.
  - Otherwise go to DROP.
- **LOAD**, other events:
  - `rx_eof` with `cnt` > 0 → COMMIT; latch `rx_dsc`.
  - `rx_eof` with `cnt` = 0 → IDLE, no commit.
  - `rx_err` → IDLE.
  - `rx_start` → restart LOAD with `cnt` := 0; the partial frame is discarded.
- **COMMIT**: drive `b_next` for one cycle, then go to IDLE.
- **DROP**: remain until `rx_eof`, `rx_err` or `rx_start` (restart LOAD); never commit.

Priority within one cycle: `rx_err` > `rx_start` > `rx_eof` > `rx_byte_vld`.

Host side:
- `rel_rx_buf` while `not_empty`=1 → `a_next` pulse. While empty the command is ignored.
- `a_next` and `b_next` in the same cycle are both driven; the FIFO resolves them.

Status and interrupts:
- `rbs` = `not_empty`, registered.
- `dos` sets on `overflow` and clears on `clr_ovr`; set wins if both occur in the same cycle.
- `rx_irq` = `rie` & `rbs`, as a level.
- `ovr_irq` sets on the rising edge of `dos` when `oie`=1, and clears on `clr_ovr` or on `oie`=0.
- `busy`=1 in LOAD, DROP and COMMIT.

Reset values:
- All outputs 0, except `b_wrn`=1.
- State IDLE, `cnt`=0.
- Reset during a load abandons the frame; no `b_next` is issued.

## Timing
- Byte write: `b_addr`, `b_din` and `b_wrn`=0 are registered and appear one cycle after `rx_byte_vld`, for exactly one cycle.
- `fifo_dsc` is held valid from latch until COMMIT exits.
- `b_next` is asserted two cycles after `rx_eof`. The last `b_wrn` is therefore complete before commit, even if `rx_byte_vld` and `rx_eof` fall on consecutive cycles.
- `a_next` is asserted one cycle after `rel_rx_buf`.
- `rbs`, `rx_irq` and `dos` follow their sources with one register stage.
- Back-to-back frames: `rx_start` is accepted in the cycle after COMMIT.

## Structure
- Shared package `can_rx_pkg`:
  - state encoding (IDLE, LOAD, DROP, COMMIT);
  - `P_MAX_BYTES` default;
  - FIFO address width (4).
- One natural sub-module, `rx_irq_gen`: the `dos`/`rbs`/interrupt logic, kept separate from the load FSM.

## Test plan
- **Normal frame:** `rx_start`, 10 bytes 0x00..0x09, `rx_eof`, `rx_dsc`=2'b10 → writes at addresses 0..9 with matching data, `fifo_dsc`=2'b10, single `b_next`, `rbs`=1, `rx_irq`=1 when `rie`=1.
- **Aborted frame:** 5 bytes then `rx_err` → 5 writes, no `b_next`, `busy`=0, `rbs` unchanged.
- **Oversize frame:** 12 bytes with `P_MAX_BYTES`=10, then `rx_eof` → 10 writes, no commit, FSM back in IDLE.
- **Overrun:** 4 frames without release; FIFO pulses `overflow` → `dos`=1, `ovr_irq`=1 with `oie`=1; `clr_ovr` → both 0; `overflow` and `clr_ovr` together → `dos`=1.
- **Release handling:** `rel_rx_buf` while empty → no `a_next`. `rel_rx_buf` in the same cycle as COMMIT → `a_next` and `b_next` both asserted.
- **Reset mid-load:** `nreset` low after 3 bytes → `b_wrn`=1, `b_next`=0, IDLE; the next frame loads from address 0.

Source files
------------

// File: rtl/can_rx_pkg.sv
// Shared definitions for the Basic CAN receive path: load FSM encoding,
// frame size limits and FIFO addressing.
package can_rx_pkg;

    localparam int ADDR_W = 4;
    localparam int CNT_W = ADDR_W + 1;
    localparam int P_MAX_BYTES_DEF = 10;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_DROP   = 2'd2;
    localparam logic [1:0] ST_COMMIT = 2'd3;

    function automatic logic is_busy(input logic [1:0] st);
        return st != ST_IDLE;
    endfunction

endpackage

// File: rtl/rx_irq_gen.sv
// Receive buffer / data overrun status and the receive and overrun interrupts.
module rx_irq_gen (
    input  logic clk,
    input  logic nreset,
    input  logic not_empty,
    input  logic overflow,
    input  logic clr_ovr,
    input  logic rie,
    input  logic oie,
    output logic rbs,
    output logic dos,
    output logic rx_irq,
    output logic ovr_irq
);

    logic rbs_q;
    logic dos_q, dos_d;
    logic ovr_irq_q, ovr_irq_d;
    logic dos_rise;

    always_comb begin
        dos_d = dos_q;
        if (overflow) begin
            dos_d = 1'b1;
        end else if (clr_ovr) begin
            dos_d = 1'b0;
        end
    end

    // Edge taken on the next-state value so the interrupt rises together with dos.
    assign dos_rise = dos_d & ~dos_q;

    always_comb begin
        ovr_irq_d = ovr_irq_q;
        if (dos_rise && oie) begin
            ovr_irq_d = 1'b1;
        end else if (clr_ovr || !oie) begin
            ovr_irq_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rbs_q     <= 1'b0;
            dos_q     <= 1'b0;
            ovr_irq_q <= 1'b0;
        end else begin
            rbs_q     <= not_empty;
            dos_q     <= dos_d;
            ovr_irq_q <= ovr_irq_d;
        end
    end

    assign rbs     = rbs_q;
    assign dos     = dos_q;
    assign rx_irq  = rie & rbs_q;
    assign ovr_irq = ovr_irq_q;

endmodule

// File: rtl/rx_fifo_seq.sv
// Receive-path sequencer: loads frame bytes into the FIFO input slot, commits or
// discards the slot, and turns host commands into FIFO release pulses.
module rx_fifo_seq
    import can_rx_pkg::*;
#(
    parameter int P_MAX_BYTES = P_MAX_BYTES_DEF
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       rx_start,
    input  logic [7:0] rx_byte,
    input  logic       rx_byte_vld,
    input  logic       rx_eof,
    input  logic       rx_err,
    input  logic [1:0] rx_dsc,
    input  logic       rel_rx_buf,
    input  logic       clr_ovr,
    input  logic       rie,
    input  logic       oie,
    output logic [3:0] b_addr,
    output logic [7:0] b_din,
    output logic       b_wrn,
    output logic       b_next,
    output logic [1:0] fifo_dsc,
    output logic       a_next,
    input  logic       not_empty,
    input  logic       full,
    input  logic       overflow,
    output logic       rbs,
    output logic       dos,
    output logic       rx_irq,
    output logic       ovr_irq,
    output logic       busy
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(P_MAX_BYTES);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        dsc_q, dsc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        din_q, din_d;
    logic              wr_d;
    logic              wrn_q;
    logic              b_next_q;
    logic              a_next_q;

    // Full is informational only; a lost frame is reported through overflow.
    logic unused_full;
    assign unused_full = full;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dsc_d   = dsc_q;
        addr_d  = addr_q;
        din_d   = din_q;
        wr_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rx_err && rx_start) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end
            end
            ST_LOAD: begin
                if (rx_err) begin
                    state_d = ST_IDLE;
                end else if (rx_start) begin
                    cnt_d = '0;
                end else if (rx_eof) begin
                    if (cnt_q != '0) begin
                        state_d = ST_COMMIT;
                        dsc_d   = rx_dsc;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (rx_byte_vld) begin
                    if (cnt_q < MAX_CNT) begin
                        wr_d   = 1'b1;
                        addr_d = cnt_q[ADDR_W-1:0];
                        din_d  = rx_byte;
                        cnt_d  = cnt_q + CNT_W'(1);
                    end else begin
                        state_d = ST_DROP;
                    end
                end
            end
            ST_DROP: begin
                if (rx_err) begin
                    state_d = ST_IDLE;
                end else if (rx_start) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end else if (rx_eof) begin
                    state_d = ST_IDLE;
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // b_next is taken from the registered COMMIT state, which places it two
    // cycles after rx_eof and strictly after the last write strobe.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            dsc_q    <= 2'b00;
            addr_q   <= '0;
            din_q    <= 8'h00;
            wrn_q    <= 1'b1;
            b_next_q <= 1'b0;
            a_next_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dsc_q    <= dsc_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            wrn_q    <= ~wr_d;
            b_next_q <= (state_q == ST_COMMIT);
            a_next_q <= rel_rx_buf & not_empty;
        end
    end

    assign b_addr   = addr_q;
    assign b_din    = din_q;
    assign b_wrn    = wrn_q;
    assign b_next   = b_next_q;
    assign fifo_dsc = dsc_q;
    assign a_next   = a_next_q;
    assign busy     = is_busy(state_q);

    rx_irq_gen u_irq (
        .clk       (clk),
        .nreset    (nreset),
        .not_empty (not_empty),
        .overflow  (overflow),
        .clr_ovr   (clr_ovr),
        .rie       (rie),
        .oie       (oie),
        .rbs       (rbs),
        .dos       (dos),
        .rx_irq    (rx_irq),
        .ovr_irq   (ovr_irq)
    );

endmodule

// File: tb/tb_rx_fifo_seq.sv
// Bench for rx_fifo_seq: scoreboarded FIFO writes and commits plus a small
// FIFO occupancy model feeding not_empty/full/overflow.
module tb_rx_fifo_seq;

    localparam int MAX_BYTES = 10;
    localparam int FIFO_CAP = 3;

    logic       clk = 1'b0;
    logic       nreset;
    logic       rx_start, rx_byte_vld, rx_eof, rx_err;
    logic [7:0] rx_byte;
    logic [1:0] rx_dsc;
    logic       rel_rx_buf, clr_ovr, rie, oie;
    logic [3:0] b_addr;
    logic [7:0] b_din;
    logic       b_wrn, b_next, a_next;
    logic [1:0] fifo_dsc;
    logic       not_empty, full, overflow;
    logic       rbs, dos, rx_irq, ovr_irq, busy;

    int         occ;
    logic       ovf_q;
    logic       ovf_force;

    int         n_chk = 0;
    int         n_fail = 0;
    int         b_cnt = 0;
    int         a_cnt = 0;
    int         snap;

    logic [11:0] wr_q[$];
    logic [1:0]  cm_q[$];
    logic [4:0]  mcnt;
    bit          mdrop;

    always #5 clk = ~clk;

    rx_fifo_seq #(.P_MAX_BYTES(MAX_BYTES)) dut (
        .clk         (clk),
        .nreset      (nreset),
        .rx_start    (rx_start),
        .rx_byte     (rx_byte),
        .rx_byte_vld (rx_byte_vld),
        .rx_eof      (rx_eof),
        .rx_err      (rx_err),
        .rx_dsc      (rx_dsc),
        .rel_rx_buf  (rel_rx_buf),
        .clr_ovr     (clr_ovr),
        .rie         (rie),
        .oie         (oie),
        .b_addr      (b_addr),
        .b_din       (b_din),
        .b_wrn       (b_wrn),
        .b_next      (b_next),
        .fifo_dsc    (fifo_dsc),
        .a_next      (a_next),
        .not_empty   (not_empty),
        .full        (full),
        .overflow    (overflow),
        .rbs         (rbs),
        .dos         (dos),
        .rx_irq      (rx_irq),
        .ovr_irq     (ovr_irq),
        .busy        (busy)
    );

    // FIFO occupancy model
    always @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            occ   <= 0;
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= b_next && !a_next && occ == FIFO_CAP;
            if (b_next && !a_next && occ < FIFO_CAP) occ <= occ + 1;
            else if (a_next && !b_next && occ > 0) occ <= occ - 1;
        end
    end
    assign not_empty = occ != 0;
    assign full      = occ == FIFO_CAP;
    assign overflow  = ovf_q | ovf_force;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (nreset === 1'b1) begin
            if (b_wrn === 1'b0) begin
                if (wr_q.size() == 0) check("unexpected_write", {20'h0, b_addr, b_din}, 32'hFFFF);
                else check("write", {20'h0, b_addr, b_din}, {20'h0, wr_q.pop_front()});
            end
            if (b_next === 1'b1) begin
                b_cnt++;
                if (cm_q.size() == 0) check("unexpected_commit", {30'h0, fifo_dsc}, 32'hF);
                else check("commit_dsc", {30'h0, fifo_dsc}, {30'h0, cm_q.pop_front()});
            end
            if (a_next === 1'b1) a_cnt++;
        end
    end

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        rx_start = 1'b1;
        mcnt = '0;
        mdrop = 1'b0;
        tick();
        rx_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte = b;
        rx_byte_vld = 1'b1;
        if (!mdrop) begin
            if (mcnt < 5'(MAX_BYTES)) begin
                wr_q.push_back({mcnt[3:0], b});
                mcnt = mcnt + 5'd1;
            end else begin
                mdrop = 1'b1;
            end
        end
        tick();
        rx_byte_vld = 1'b0;
    endtask

    task automatic end_frame(input logic [1:0] dsc, input bit rel_with_commit);
        bit commit;
        commit = !mdrop && mcnt != 0;
        rx_eof = 1'b1;
        rx_dsc = dsc;
        if (commit) cm_q.push_back(dsc);
        tick();
        rx_eof = 1'b0;
        if (rel_with_commit) rel_rx_buf = 1'b1;
        @(negedge clk);
        check("b_next_early", {31'h0, b_next}, 32'h0);
        check("busy_after_eof", {31'h0, busy}, {31'h0, commit});
        tick();
        rel_rx_buf = 1'b0;
        @(negedge clk);
        check("b_next_timing", {31'h0, b_next}, {31'h0, commit});
        if (rel_with_commit) check("a_next_with_commit", {31'h0, a_next}, 32'h1);
        tick();
    endtask

    task automatic frame(input int n, input logic [7:0] base, input logic [1:0] dsc,
                         input bit rel_with_commit);
        start_frame();
        for (int i = 0; i < n; i++) send_byte(base + 8'(i));
        end_frame(dsc, rel_with_commit);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nreset = 1'b0;
        {rx_start, rx_byte_vld, rx_eof, rx_err, rel_rx_buf, clr_ovr, ovf_force} = '0;
        rx_byte = 8'h00;
        rx_dsc = 2'b00;
        rie = 1'b1;
        oie = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_b_wrn", {31'h0, b_wrn}, 32'h1);
        check("rst_outs", {20'h0, b_addr, b_din}, 32'h0);
        check("rst_flags", {24'h0, b_next, a_next, fifo_dsc, rbs, dos, rx_irq, ovr_irq},
              32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        nreset = 1'b1;
        tick();

        // Normal 10-byte frame
        frame(10, 8'h00, 2'b10, 1'b0);
        tick();
        check("normal_commits", b_cnt, 1);
        check("normal_rbs", {31'h0, rbs}, 32'h1);
        check("normal_rx_irq", {31'h0, rx_irq}, 32'h1);

        // Aborted frame
        snap = b_cnt;
        start_frame();
        for (int i = 0; i < 5; i++) send_byte(8'h40 + 8'(i));
        rx_err = 1'b1;
        tick();
        rx_err = 1'b0;
        repeat (3) tick();
        check("abort_no_commit", b_cnt, snap);
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_rbs", {31'h0, rbs}, 32'h1);

        // Oversize frame: only the first 10 bytes written, no commit
        snap = b_cnt;
        frame(12, 8'h80, 2'b01, 1'b0);
        repeat (2) tick();
        check("oversize_no_commit", b_cnt, snap);
        check("oversize_idle", {31'h0, busy}, 32'h0);

        // Release: first one drains the FIFO, second is ignored while empty
        snap = a_cnt;
        rel_rx_buf = 1'b1;
        tick();
        rel_rx_buf = 1'b0;
        repeat (3) tick();
        check("release_a_next", a_cnt, snap + 1);
        check("release_rbs", {31'h0, rbs}, 32'h0);
        check("release_rx_irq", {31'h0, rx_irq}, 32'h0);
        rel_rx_buf = 1'b1;
        tick();
        rel_rx_buf = 1'b0;
        repeat (3) tick();
        check("release_empty_ignored", a_cnt, snap + 1);

        // Release coinciding with commit
        frame(3, 8'hA0, 2'b11, 1'b0);
        tick();
        frame(4, 8'hB0, 2'b01, 1'b1);
        repeat (2) tick();
        check("rel_commit_occ", occ, 1);

        // Overrun: restart mid-frame, then fill the FIFO past capacity
        start_frame();
        send_byte(8'hC0);
        send_byte(8'hC1);
        start_frame();
        for (int i = 0; i < 3; i++) send_byte(8'hD0 + 8'(i));
        end_frame(2'b10, 1'b0);
        frame(2, 8'hE0, 2'b00, 1'b0);
        check("ovr_dos_pre", {31'h0, dos}, 32'h0);
        frame(6, 8'hF0, 2'b01, 1'b0);
        repeat (3) tick();
        check("ovr_dos", {31'h0, dos}, 32'h1);
        check("ovr_irq", {31'h0, ovr_irq}, 32'h1);
        repeat (3) tick();
        check("ovr_dos_sticky", {31'h0, dos}, 32'h1);
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        tick();
        check("clr_dos", {31'h0, dos}, 32'h0);
        check("clr_ovr_irq", {31'h0, ovr_irq}, 32'h0);
        ovf_force = 1'b1;
        clr_ovr = 1'b1;
        tick();
        ovf_force = 1'b0;
        clr_ovr = 1'b0;
        tick();
        check("set_wins_dos", {31'h0, dos}, 32'h1);
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;

        // Reset mid-load
        start_frame();
        for (int i = 0; i < 3; i++) send_byte(8'h50 + 8'(i));
        tick();
        nreset = 1'b0;
        #3;
        check("midrst_b_wrn", {31'h0, b_wrn}, 32'h1);
        check("midrst_b_next", {31'h0, b_next}, 32'h0);
        check("midrst_busy", {31'h0, busy}, 32'h0);
        tick();
        nreset = 1'b1;
        tick();
        snap = b_cnt;
        frame(2, 8'h60, 2'b01, 1'b0);
        tick();
        check("post_reset_commit", b_cnt, snap + 1);

        check("writes_drained", wr_q.size(), 0);
        check("commits_drained", cm_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
